// File: rtl/ppu_reg_port_pkg.sv
// PPU register port shared constants.
// Register offsets, VRAM address width, VRAM FSM encodings.
package ppu_reg_port_pkg;

  localparam int VADDR_WIDTH = 14;

  localparam logic [2:0] PPU_CTRL    = 3'd0;
  localparam logic [2:0] PPU_MASK    = 3'd1;
  localparam logic [2:0] PPU_STATUS  = 3'd2;
  localparam logic [2:0] PPU_OAMADDR = 3'd3;
  localparam logic [2:0] PPU_OAMDATA = 3'd4;
  localparam logic [2:0] PPU_SCROLL  = 3'd5;
  localparam logic [2:0] PPU_ADDR    = 3'd6;
  localparam logic [2:0] PPU_DATA    = 3'd7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/ppu_vram_if.sv
// VRAM req/ack bridge for PPUDATA accesses.
// Holds the captured address/data and the PPUDATA read buffer.
module ppu_vram_if
  import ppu_reg_port_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic                   phi0,
  input  logic                   reset,
  input  logic                   start_rd,
  input  logic                   start_wr,
  input  logic [VADDR_WIDTH-1:0] addr_in,
  input  logic [DW-1:0]          wdata_in,
  input  logic [DW-1:0]          vram_rdata,
  input  logic                   vram_ack,
  output logic [VADDR_WIDTH-1:0] vram_addr,
  output logic [DW-1:0]          vram_wdata,
  output logic                   vram_rd_req,
  output logic                   vram_wr_req,
  output logic [DW-1:0]          read_buf,
  output logic                   idle
);

  logic [1:0]             r_state;
  logic [VADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]          r_wdata;
  logic [DW-1:0]          r_read_buf;

  // Request FSM: capture on start, hold until ack, ignore stray acks.
  always_ff @(posedge phi0 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_read_buf <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start_rd) begin
            r_state <= ST_RD_WAIT;
            r_addr  <= addr_in;
          end else if (start_wr) begin
            r_state <= ST_WR_WAIT;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
          end
        end
        ST_RD_WAIT: begin
          if (vram_ack) begin
            r_read_buf <= vram_rdata;
            r_state    <= ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (vram_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vram_addr   = r_addr;
  assign vram_wdata  = r_wdata;
  assign vram_rd_req = (r_state == ST_RD_WAIT);
  assign vram_wr_req = (r_state == ST_WR_WAIT);
  assign read_buf    = r_read_buf;
  assign idle        = (r_state == ST_IDLE);

endmodule

// File: rtl/ppu_reg_port.sv
// PPU CPU-bus register window ($2000-$3FFF, 8-byte mirror).
// Register decode, write toggle, t/v address, vblank and NMI.
module ppu_reg_port
  import ppu_reg_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8,
  localparam int SEL_W = (ADDR_WIDTH < 3) ? ADDR_WIDTH : 3
)(
  input  logic                   phi0,
  input  logic                   reset,
  input  logic                   bus_en,
  input  logic [SEL_W-1:0]       A,
  input  logic                   R_W_n,
  input  logic [REG_WIDTH-1:0]   d_in,
  output logic [REG_WIDTH-1:0]   d_out,
  output logic                   d_oe,
  output logic                   rdy,
  output logic                   nmi_n,
  input  logic                   vblank_set,
  input  logic                   vblank_clr,
  input  logic                   spr0_hit,
  input  logic                   spr_ovf,
  output logic [REG_WIDTH-1:0]   ctrl,
  output logic [REG_WIDTH-1:0]   mask,
  output logic [REG_WIDTH-1:0]   scroll_x,
  output logic [REG_WIDTH-1:0]   scroll_y,
  output logic [REG_WIDTH-1:0]   oam_addr,
  output logic [REG_WIDTH-1:0]   oam_wdata,
  output logic                   oam_we,
  input  logic [REG_WIDTH-1:0]   oam_rdata,
  output logic [VADDR_WIDTH-1:0] vram_addr,
  output logic [REG_WIDTH-1:0]   vram_wdata,
  output logic                   vram_rd_req,
  output logic                   vram_wr_req,
  input  logic [REG_WIDTH-1:0]   vram_rdata,
  input  logic                   vram_ack
);

  logic [REG_WIDTH-1:0]   r_ctrl;
  logic [REG_WIDTH-1:0]   r_mask;
  logic [REG_WIDTH-1:0]   r_scroll_x;
  logic [REG_WIDTH-1:0]   r_scroll_y;
  logic [REG_WIDTH-1:0]   r_oam_addr;
  logic [REG_WIDTH-1:0]   r_io_latch;
  logic [VADDR_WIDTH-1:0] r_t;
  logic [VADDR_WIDTH-1:0] r_v;
  logic                   r_w;
  logic                   r_vblank;

  logic                   w_idle;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_status_rd;
  logic [VADDR_WIDTH-1:0] w_t_next;
  logic [VADDR_WIDTH-1:0] w_v_inc;
  logic [REG_WIDTH-1:0]   w_read_buf;

  assign w_rd        = bus_en & w_idle & R_W_n;
  assign w_wr        = bus_en & w_idle & ~R_W_n;
  assign w_status_rd = w_rd & (A == PPU_STATUS);
  assign w_v_inc     = r_v + (r_ctrl[2] ? VADDR_WIDTH'(32) : VADDR_WIDTH'(1));

  // Next t: PPUADDR writes fill the high byte first, then the low byte.
  always_comb begin
    w_t_next = r_t;
    if (w_wr && A == PPU_ADDR) begin
      if (!r_w) w_t_next = {d_in[5:0], r_t[7:0]};
      else      w_t_next = {r_t[13:8], d_in[7:0]};
    end
  end

  // Read mux; write-only offsets echo the open-bus latch.
  always_comb begin
    d_out = r_io_latch;
    unique case (A)
      PPU_STATUS:  d_out = {r_vblank, spr0_hit, spr_ovf,
                            r_io_latch[REG_WIDTH-4:0]};
      PPU_OAMDATA: d_out = oam_rdata;
      PPU_DATA:    d_out = w_read_buf;
      default:     ;
    endcase
  end

  // Register file, write toggle and VRAM address updates.
  always_ff @(posedge phi0 or posedge reset) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_mask     <= '0;
      r_scroll_x <= '0;
      r_scroll_y <= '0;
      r_oam_addr <= '0;
      r_io_latch <= '0;
      r_t        <= '0;
      r_v        <= '0;
      r_w        <= 1'b0;
    end else begin
      r_t <= w_t_next;
      if (w_wr) begin
        r_io_latch <= d_in;
        unique case (A)
          PPU_CTRL:    r_ctrl     <= d_in;
          PPU_MASK:    r_mask     <= d_in;
          PPU_OAMADDR: r_oam_addr <= d_in;
          PPU_OAMDATA: r_oam_addr <= r_oam_addr + REG_WIDTH'(1);
          PPU_SCROLL: begin
            if (!r_w) r_scroll_x <= d_in;
            else      r_scroll_y <= d_in;
            r_w <= ~r_w;
          end
          PPU_ADDR: begin
            if (r_w) r_v <= w_t_next;
            r_w <= ~r_w;
          end
          PPU_DATA:    r_v <= w_v_inc;
          default:     ;
        endcase
      end else if (w_rd) begin
        if (A == PPU_STATUS) r_w <= 1'b0;
        if (A == PPU_DATA)   r_v <= w_v_inc;
      end
    end
  end

  // vblank flag: a status read in the same cycle suppresses the set.
  always_ff @(posedge phi0 or posedge reset) begin
    if (reset)            r_vblank <= 1'b0;
    else if (vblank_clr)  r_vblank <= 1'b0;
    else if (w_status_rd) r_vblank <= 1'b0;
    else if (vblank_set)  r_vblank <= 1'b1;
  end

  ppu_vram_if #(
    .DW (REG_WIDTH)
  ) u_vram_if (
    .phi0        (phi0),
    .reset       (reset),
    .start_rd    (w_rd & (A == PPU_DATA)),
    .start_wr    (w_wr & (A == PPU_DATA)),
    .addr_in     (r_v),
    .wdata_in    (d_in),
    .vram_rdata  (vram_rdata),
    .vram_ack    (vram_ack),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_rd_req (vram_rd_req),
    .vram_wr_req (vram_wr_req),
    .read_buf    (w_read_buf),
    .idle        (w_idle)
  );

  assign rdy       = w_idle;
  assign d_oe      = w_rd;
  assign nmi_n     = ~(r_vblank & r_ctrl[7]);
  assign oam_we    = w_wr & (A == PPU_OAMDATA);
  assign oam_wdata = d_in;
  assign ctrl      = r_ctrl;
  assign mask      = r_mask;
  assign scroll_x  = r_scroll_x;
  assign scroll_y  = r_scroll_y;
  assign oam_addr  = r_oam_addr;

endmodule

// File: tb/tb_ppu_reg_port.sv
// Bench for ppu_reg_port: directed plan steps plus random
// accesses checked against a register-level model.
module tb_ppu_reg_port;

  logic        phi0 = 1'b0;
  logic        reset;
  logic        bus_en;
  logic [2:0]  A;
  logic        R_W_n;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        rdy;
  logic        nmi_n;
  logic        vblank_set;
  logic        vblank_clr;
  logic        spr0_hit;
  logic        spr_ovf;
  logic [7:0]  ctrl;
  logic [7:0]  mask;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_rd_req;
  logic        vram_wr_req;
  logic [7:0]  vram_rdata;
  logic        vram_ack;

  ppu_reg_port dut (
    .phi0        (phi0),
    .reset       (reset),
    .bus_en      (bus_en),
    .A           (A),
    .R_W_n       (R_W_n),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .rdy         (rdy),
    .nmi_n       (nmi_n),
    .vblank_set  (vblank_set),
    .vblank_clr  (vblank_clr),
    .spr0_hit    (spr0_hit),
    .spr_ovf     (spr_ovf),
    .ctrl        (ctrl),
    .mask        (mask),
    .scroll_x    (scroll_x),
    .scroll_y    (scroll_y),
    .oam_addr    (oam_addr),
    .oam_wdata   (oam_wdata),
    .oam_we      (oam_we),
    .oam_rdata   (oam_rdata),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_rd_req (vram_rd_req),
    .vram_wr_req (vram_wr_req),
    .vram_rdata  (vram_rdata),
    .vram_ack    (vram_ack)
  );

  always #5 phi0 = ~phi0;

  int checks = 0;
  int passes = 0;

  // Reference model state (plain integers / bytes).
  logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_oam, m_buf, m_latch;
  int         m_t, m_v;
  bit         m_w, m_vb;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_oam = 0;
    m_buf = 0; m_latch = 0; m_t = 0; m_v = 0; m_w = 0; m_vb = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_ctrl"}, ctrl, m_ctrl);
    chk({tag, "_mask"}, mask, m_mask);
    chk({tag, "_sx"}, scroll_x, m_sx);
    chk({tag, "_sy"}, scroll_y, m_sy);
    chk({tag, "_oam"}, oam_addr, m_oam);
    chk({tag, "_nmi"}, nmi_n, !(m_vb && m_ctrl[7]));
  endtask

  // One idle cycle with optional vblank pulses.
  task automatic pulse(input bit vs, input bit vc);
    vblank_set = vs; vblank_clr = vc;
    @(posedge phi0); #1;
    vblank_set = 0; vblank_clr = 0;
    if (vc) m_vb = 0;
    else if (vs) m_vb = 1;
    chk_regs("pulse");
  endtask

  // One accepted CPU access; PPUDATA accesses also run the handshake.
  task automatic do_access(input bit rd, input logic [2:0] a,
                           input logic [7:0] d, input bit vs,
                           input bit vc, input int dly,
                           input logic [7:0] rdat, input bit probe);
    logic [7:0] exp_d;
    int pv, inc;
    chk("rdy_pre", rdy, 1);
    bus_en = 1; R_W_n = rd; A = a; d_in = d;
    vblank_set = vs; vblank_clr = vc;
    oam_rdata = 8'($urandom);
    #4;
    case (a)
      3'd2:    exp_d = {m_vb, spr0_hit, spr_ovf, m_latch[4:0]};
      3'd4:    exp_d = oam_rdata;
      3'd7:    exp_d = m_buf;
      default: exp_d = m_latch;
    endcase
    chk("d_oe", d_oe, rd);
    if (rd) chk("d_out", d_out, exp_d);
    chk("oam_we", oam_we, (!rd && a == 3'd4));
    if (!rd && a == 3'd4) begin
      chk("oam_wdata", oam_wdata, d);
      chk("oam_we_addr", oam_addr, m_oam);
    end
    pv  = m_v;
    inc = m_ctrl[2] ? 32 : 1;
    if (!rd) m_latch = d;
    case (a)
      3'd0: if (!rd) m_ctrl = d;
      3'd1: if (!rd) m_mask = d;
      3'd2: if (rd) m_w = 0;
      3'd3: if (!rd) m_oam = d;
      3'd4: if (!rd) m_oam = m_oam + 8'd1;
      3'd5: if (!rd) begin
        if (!m_w) m_sx = d; else m_sy = d;
        m_w = !m_w;
      end
      3'd6: if (!rd) begin
        if (!m_w) m_t = (d % 64) * 256 + (m_t % 256);
        else begin
          m_t = (m_t / 256) * 256 + d;
          m_v = m_t;
        end
        m_w = !m_w;
      end
      default: m_v = (m_v + inc) % 16384;
    endcase
    if (vc) m_vb = 0;
    else if (rd && a == 3'd2) m_vb = 0;
    else if (vs) m_vb = 1;
    @(posedge phi0); #1;
    bus_en = 0; vblank_set = 0; vblank_clr = 0;
    chk_regs("acc");
    if (a == 3'd7) begin
      chk("rd_req", vram_rd_req, rd);
      chk("wr_req", vram_wr_req, !rd);
      chk("vaddr", vram_addr, pv);
      if (!rd) chk("vwdata", vram_wdata, d);
      chk("rdy_stall", rdy, 0);
      for (int i = 0; i < dly; i++) begin
        if (probe && i == 0) begin
          bus_en = 1; R_W_n = 0; A = 3'd0; d_in = ~m_ctrl;
          #4;
          chk("stall_oe", d_oe, 0);
          @(posedge phi0); #1;
          bus_en = 0;
          chk("stall_ctrl", ctrl, m_ctrl);
        end else begin
          @(posedge phi0); #1;
        end
        chk("hold_req", vram_rd_req | vram_wr_req, 1);
        chk("hold_addr", vram_addr, pv);
        chk("hold_rdy", rdy, 0);
      end
      vram_ack = 1; vram_rdata = rdat;
      @(posedge phi0); #1;
      vram_ack = 0;
      chk("rdy_post", rdy, 1);
      chk("req_post", vram_rd_req | vram_wr_req, 0);
      if (rd) m_buf = rdat;
    end
  endtask

  initial begin
    reset = 1; bus_en = 0; A = 0; R_W_n = 1; d_in = 0;
    vblank_set = 0; vblank_clr = 0; spr0_hit = 0; spr_ovf = 0;
    oam_rdata = 0; vram_rdata = 0; vram_ack = 0;
    model_reset();
    @(posedge phi0); #1;
    reset = 0;

    chk("rst_rdy", rdy, 1);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_rdreq", vram_rd_req, 0);
    chk("rst_wrreq", vram_wr_req, 0);
    chk("rst_oam_we", oam_we, 0);
    chk_regs("rst");

    // PPUADDR $2108, then PPUDATA write; v increments to $2109.
    do_access(0, 3'd6, 8'h21, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd6, 8'h08, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd7, 8'hAB, 0, 0, 2, 8'h00, 1);
    do_access(0, 3'd7, 8'hCD, 0, 0, 0, 8'h00, 0);

    // +32 increment wrapping past $3FFF; read buffer delay.
    do_access(0, 3'd0, 8'h04, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd6, 8'h3F, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd6, 8'hF0, 0, 0, 0, 8'h00, 0);
    do_access(1, 3'd7, 8'h00, 0, 0, 0, 8'h11, 0);
    do_access(1, 3'd7, 8'h00, 0, 0, 1, 8'h22, 0);
    do_access(1, 3'd7, 8'h00, 0, 0, 0, 8'h33, 0);

    // NMI on vblank, cleared by status read.
    do_access(0, 3'd0, 8'h80, 0, 0, 0, 8'h00, 0);
    pulse(1, 0);
    chk("nmi_low", nmi_n, 0);
    do_access(1, 3'd2, 8'h00, 0, 0, 0, 8'h00, 0);
    chk("nmi_high", nmi_n, 1);

    // Status read racing vblank_set suppresses the set.
    do_access(1, 3'd2, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("race_nmi", nmi_n, 1);
    pulse(1, 1);
    chk("clr_prio_nmi", nmi_n, 1);

    // Status read resets the write toggle.
    do_access(0, 3'd5, 8'h10, 0, 0, 0, 8'h00, 0);
    do_access(1, 3'd2, 8'h00, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd5, 8'h20, 0, 0, 0, 8'h00, 0);
    chk("scroll_x_20", scroll_x, 8'h20);
    chk("scroll_y_00", scroll_y, 8'h00);

    // OAM address wrap after OAMDATA write at $FF.
    do_access(0, 3'd3, 8'hFF, 0, 0, 0, 8'h00, 0);
    do_access(0, 3'd4, 8'h5A, 0, 0, 0, 8'h00, 0);
    chk("oam_wrap", oam_addr, 8'h00);

    // Reset while waiting on a write ack, then a stray ack.
    bus_en = 1; R_W_n = 0; A = 3'd7; d_in = 8'h77;
    @(posedge phi0); #1;
    bus_en = 0;
    chk("wr_wait_req", vram_wr_req, 1);
    reset = 1;
    #2;
    chk("rst_mid_req", vram_wr_req, 0);
    chk("rst_mid_rdy", rdy, 1);
    @(posedge phi0); #1;
    reset = 0;
    model_reset();
    vram_ack = 1;
    @(posedge phi0); #1;
    vram_ack = 0;
    chk("late_ack_rdy", rdy, 1);
    chk("late_ack_req", vram_rd_req | vram_wr_req, 0);

    // Random accesses against the model.
    for (int n = 0; n < 300; n++) begin
      int dly;
      spr0_hit = 1'($urandom);
      spr_ovf  = 1'($urandom);
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0)
        pulse($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      do_access($urandom_range(0, 1) == 1,
                3'($urandom_range(0, 7)),
                8'($urandom),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                dly,
                8'($urandom),
                (dly > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
